combination_enumerator: RTL
===========================

COMBINATION_ENUMERATOR -- requirements
Module: combination_enumerator

Interface
REQ-001 Parameter SIZE, default 5; width of the element vector and of each emitted mask.
REQ-002 Parameter IDXW, default 8; width of the mask index counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 start  input  1  request to begin enumeration; honoured only in IDLE.
REQ-006 r  input  3  number of set bits per mask; sampled only on an accepted start.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 m_valid  output  1  mask presented to the downstream OR-combination evaluator.
REQ-009 m_ready  input  1  downstream accepts the mask; transfer occurs when m_valid and m_ready are both high.
REQ-010 m_mask  output  SIZE  current combination; bit i set means element i is selected.
REQ-011 m_last  output  1  high with m_valid on the final mask of the sequence.
REQ-012 m_index  output  IDXW  zero-based ordinal of the current mask.
REQ-013 done  output  1  one-cycle pulse after the last transfer.
REQ-014 err  output  1  one-cycle pulse when start carries an illegal r.

Function
REQ-015 The FSM shall have states IDLE, EMIT and DONE.
REQ-016 In IDLE with start=1 and 1<=r<=SIZE, the block shall latch r, load m_mask=(1<<r)-1 and m_index=0, and enter EMIT; m_valid shall be high in the following cycle.
REQ-017 In IDLE with start=1 and r=0 or r>SIZE, the block shall pulse err for one cycle, remain in IDLE and emit no mask.
REQ-018 In EMIT, m_valid shall be high; m_mask, m_index and m_last shall hold stable while m_ready=0.
REQ-019 On a transfer without m_last, m_mask shall advance to the next-larger SIZE-bit value with the same popcount (lexicographic order), and m_index shall increment by 1.
REQ-020 m_last shall be high when m_mask equals ((1<<r)-1)<<(SIZE-r); for r=SIZE this is the first and only mask.
REQ-021 On a transfer with m_last=1, the block shall enter DONE, drop m_valid and pulse done for exactly one cycle, then return to IDLE.
REQ-022 The total number of transfers per run shall equal C(SIZE,r), and m_index shall never wrap for legal parameters.
REQ-023 start shall be ignored in EMIT and DONE; start in the same cycle that DONE returns to IDLE shall not be honoured until IDLE is observed.
REQ-024 The next-mask computation shall use no divider: take the lowest set bit c, form t=m+c, and set next=t | (((t^m)>>2)>>tz(c)), where tz(c) is the trailing-zero count of c.

Reset
REQ-025 While rst_n=0 at a clock edge, the FSM shall go to IDLE, and m_valid, m_last, done, err and busy shall be 0, with m_mask and m_index set to 0.
REQ-026 A reset asserted mid-EMIT shall abort the sequence with no done pulse, and the outputs shall be at their reset values on the next cycle.

Structure
REQ-027 Package comb_pkg shall hold the default SIZE and IDXW values and the state enumeration (IDLE, EMIT, DONE).
REQ-028 The next-mask logic shall be a separate combinational sub-module, comb_next (in: mask[SIZE]; out: next[SIZE]).

Verification
REQ-029 SIZE=5, r=3, m_ready tied high: start -> 10 masks 00111, 01011, 01101, 01110, 10011, 10101, 10110, 11001, 11010, 11100; m_last on 11100 with m_index=9; done the next cycle.
REQ-030 r=5: start -> single mask 11111 with m_last=1 and m_index=0, then done.
REQ-031 r=0, then r=6: each start -> err pulse, m_valid stays 0, busy stays 0.
REQ-032 r=2, m_ready toggled 0/1 every cycle: masks and index hold while stalled; exactly 10 transfers occur, in order 00011 through 11000.
REQ-033 r=3, rst_n=0 after the 4th transfer -> next cycle all outputs are 0 and the FSM is in IDLE; a following start restarts at 00111.
REQ-034 A start pulsed during EMIT -> ignored, and the sequence and m_index are unaffected.

Source files
------------

// File: rtl/comb_pkg.sv
// Shared defaults and FSM state type for the combination enumerator.
package comb_pkg;

    localparam int unsigned SIZE_DEF = 5;
    localparam int unsigned IDXW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        DONE
    } state_e;

endpackage

// File: rtl/comb_next.sv
// Next-larger mask with equal popcount (Gosper's hack), using shifts instead of a divide.
module comb_next
    import comb_pkg::*;
#(
    parameter int unsigned SIZE = SIZE_DEF
) (
    input  logic [SIZE-1:0] mask,
    output logic [SIZE-1:0] next
);

    localparam int unsigned TZW = $clog2(SIZE + 1);

    logic [SIZE-1:0] low;
    logic [SIZE-1:0] t;
    logic [SIZE-1:0] diff;
    logic [TZW-1:0]  tz;

    always_comb begin
        low  = mask & (-mask);
        t    = mask + low;
        diff = t ^ mask;
        tz   = '0;
        // Scan downward so the lowest set bit of low wins.
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (low[i]) begin
                tz = TZW'(i);
            end
        end
        next = t | ((diff >> 2) >> tz);
    end

endmodule

// File: rtl/combination_enumerator.sv
// Streams every SIZE-bit mask with r bits set, in increasing order, over a valid/ready port.
module combination_enumerator
    import comb_pkg::*;
#(
    parameter int unsigned SIZE = SIZE_DEF,
    parameter int unsigned IDXW = IDXW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      r,
    output logic            busy,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [SIZE-1:0] m_mask,
    output logic            m_last,
    output logic [IDXW-1:0] m_index,
    output logic            done,
    output logic            err
);

    state_e          state_q, state_d;
    logic [2:0]      r_q, r_d;
    logic [SIZE-1:0] mask_q, mask_d;
    logic [IDXW-1:0] index_q, index_d;
    logic            err_q, err_d;

    logic [SIZE-1:0] next_mask;
    logic [SIZE-1:0] last_mask;
    logic            r_legal;
    logic            is_last;
    logic            xfer;

    function automatic logic [SIZE-1:0] first_of(input logic [2:0] k);
        return ~({SIZE{1'b1}} << k);
    endfunction

    comb_next #(
        .SIZE (SIZE)
    ) u_next (
        .mask (mask_q),
        .next (next_mask)
    );

    always_comb begin
        r_legal   = (r != 3'd0) && (32'(r) <= SIZE);
        last_mask = first_of(r_q) << (SIZE - 32'(r_q));
        is_last   = (mask_q == last_mask);
        xfer      = (state_q == EMIT) && m_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            mask_q  <= '0;
            index_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            mask_q  <= mask_d;
            index_q <= index_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start && r_legal) state_d = EMIT;
            EMIT:    if (m_ready && is_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        r_d     = r_q;
        mask_d  = mask_q;
        index_d = index_q;
        err_d   = 1'b0;
        if (state_q == IDLE && start) begin
            if (r_legal) begin
                r_d     = r;
                mask_d  = first_of(r);
                index_d = '0;
            end else begin
                err_d = 1'b1;
            end
        end
        if (xfer && !is_last) begin
            mask_d  = next_mask;
            index_d = index_q + IDXW'(1);
        end
    end

    always_comb begin
        busy    = (state_q != IDLE);
        m_valid = (state_q == EMIT);
        m_last  = (state_q == EMIT) && is_last;
        done    = (state_q == DONE);
        err     = err_q;
        m_mask  = mask_q;
        m_index = index_q;
    end

endmodule
